// File: rtl/fetch_debug_pkg.sv
// rtl/fetch_debug_pkg.sv - shared states and command bytes for the fetch debug controller
package fetch_debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_WORD,
        ST_LOAD_FLUSH,
        ST_RUN,
        ST_STEP
    } state_e;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_HALT = 8'h48;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/fetch_debug_ctrl_if.sv
// rtl/fetch_debug_ctrl_if.sv - UART byte input, fetch-stage control and imem write port
interface fetch_debug_ctrl_if;

    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_program_end;
    logic        o_write_instruction_mem;
    logic [31:0] o_instruction_mem_addr;
    logic [31:0] o_instruction_mem_data;
    logic        o_halt;
    logic        o_cpu_reset;
    logic        o_done;
    logic        o_busy;

    modport slave (
        input  i_rx_data, i_rx_valid, i_program_end,
        output o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data,
        output o_halt, o_cpu_reset, o_done, o_busy
    );

    modport master (
        output i_rx_data, i_rx_valid, i_program_end,
        input  o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data,
        input  o_halt, o_cpu_reset, o_done, o_busy
    );

endinterface

// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - little-endian 8-to-32 assembler, pulses once per completed word
module byte_word_assembler
    import fetch_debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [7:0]  in_tdata,
    input  logic        in_tvalid,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  idx;
    logic [23:0] partial;

    // o_word is a separate register so the write data holds between strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= 2'd0;
            partial      <= 24'd0;
            o_word       <= 32'd0;
            o_word_valid <= 1'b0;
        end else begin
            o_word_valid <= 1'b0;
            if (clear) begin
                idx     <= 2'd0;
                partial <= 24'd0;
            end else if (in_tvalid) begin
                if (idx == 2'(WORD_BYTES - 1)) begin
                    o_word       <= {in_tdata, partial};
                    o_word_valid <= 1'b1;
                    idx          <= 2'd0;
                end else begin
                    case (idx)
                        2'd0:    partial[7:0]   <= in_tdata;
                        2'd1:    partial[15:8]  <= in_tdata;
                        default: partial[23:16] <= in_tdata;
                    endcase
                    idx <= idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_debug_ctrl.sv
// rtl/fetch_debug_ctrl.sv - debug/boot sequencer: program load, run and single-step of the fetch stage
module fetch_debug_ctrl
    import fetch_debug_pkg::*;
#(
    parameter int IMEM_DEPTH = 256
)
(
    input  logic               i_clk,
    input  logic               i_reset,
    fetch_debug_ctrl_if.slave  bus
);

    localparam logic [31:0] LAST_ADDR = 32'((IMEM_DEPTH - 1) * WORD_BYTES);

    state_e      state, state_next;
    logic        done_next, cpu_reset_next, halt_next;
    logic        halt_q, done_q, cpu_reset_q;
    logic [7:0]  words_left;
    logic [31:0] addr;
    logic [31:0] word;
    logic        word_valid;
    logic        load_start, last_write, asm_valid;

    assign load_start = (state == ST_LOAD_CNT) && bus.i_rx_valid && (bus.i_rx_data != 8'd0);
    assign last_write = word_valid && (words_left == 8'd1);
    // bytes trailing the final word of a load are not part of the program
    assign asm_valid  = (state == ST_LOAD_WORD) && bus.i_rx_valid && !last_write;

    byte_word_assembler u_asm (
        .clk          (i_clk),
        .rst_n        (i_reset),
        .clear        (load_start),
        .in_tdata     (bus.i_rx_data),
        .in_tvalid    (asm_valid),
        .o_word       (word),
        .o_word_valid (word_valid)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next     = state;
        done_next      = 1'b0;
        cpu_reset_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_rx_valid) begin
                    case (bus.i_rx_data)
                        CMD_LOAD: state_next = ST_LOAD_CNT;
                        CMD_RUN:  state_next = ST_RUN;
                        CMD_STEP: state_next = ST_STEP;
                        default:  state_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD_CNT: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == 8'd0) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_LOAD_WORD;
                    end
                end
            end
            ST_LOAD_WORD: begin
                if (last_write) begin
                    state_next     = ST_LOAD_FLUSH;
                    done_next      = 1'b1;
                    cpu_reset_next = 1'b1;
                end
            end
            ST_LOAD_FLUSH: state_next = ST_IDLE;
            ST_RUN: begin
                if (bus.i_program_end || (bus.i_rx_valid && bus.i_rx_data == CMD_HALT)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            ST_STEP: begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        halt_next = !((state_next == ST_RUN) || (state_next == ST_STEP));
    end

    // pulses and halt are registered from the next state so they line up with the state they describe
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            halt_q      <= 1'b1;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b0;
            addr        <= 32'd0;
            words_left  <= 8'd0;
        end else begin
            halt_q      <= halt_next;
            done_q      <= done_next;
            cpu_reset_q <= cpu_reset_next;
            if (load_start) begin
                addr       <= 32'd0;
                words_left <= bus.i_rx_data;
            end else if (word_valid && state == ST_LOAD_WORD) begin
                addr       <= (addr == LAST_ADDR) ? 32'd0 : addr + 32'(WORD_BYTES);
                words_left <= words_left - 8'd1;
            end
        end
    end

    assign bus.o_write_instruction_mem = word_valid;
    assign bus.o_instruction_mem_addr  = addr;
    assign bus.o_instruction_mem_data  = word;
    assign bus.o_halt                  = halt_q;
    assign bus.o_cpu_reset             = cpu_reset_q;
    assign bus.o_done                  = done_q;
    assign bus.o_busy                  = (state != ST_IDLE);

endmodule
